// File: rtl/keccak_p_core_if.sv
// Start/done handshake and state bus of the Keccak-p permutation core.
// The master drives start/A_in; the core (slave) returns busy/done/A_out.
interface keccak_p_core_if #(
    parameter int W = 64
);
    logic                     start;
    logic [0:4][0:4][W-1:0]   A_in;
    logic                     busy;
    logic                     done;
    logic [0:4][0:4][W-1:0]   A_out;

    modport master (output start, A_in, input busy, done, A_out);
    modport slave  (input start, A_in, output busy, done, A_out);
endinterface

// File: rtl/keccak_p_core.sv
// Iterative Keccak-p[25*W, NR] permutation: RPC unrolled rounds per clock,
// started by a single-cycle start and finished with a one-cycle done pulse.
//   state | meaning
//   IDLE  | state register holds the last result, waiting for start
//   RUN   | RPC rounds applied per edge until NR rounds are complete
module keccak_p_core #(
    parameter int W   = 64,
    parameter int NR  = 24,
    parameter int RPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    keccak_p_core_if.slave  bus
);
    localparam int L     = $clog2(W);
    localparam int NRMAX = 12 + 2 * L;
    localparam int BASE  = NRMAX - NR;
    localparam int CW    = $clog2(NR + 1);
    localparam int IW    = $clog2(NRMAX);

    localparam int RHO [0:4][0:4] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    typedef logic [0:4][0:4][W-1:0] state_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_e;

    if ((1 << L) != W || W > 64) begin : g_bad_w
        $error("keccak_p_core: W must be a power of two between 1 and 64");
    end
    if (NR < 1 || NR > NRMAX) begin : g_bad_nr
        $error("keccak_p_core: NR out of range for this lane width");
    end
    if (RPC < 1 || (NR % RPC) != 0) begin : g_bad_rpc
        $error("keccak_p_core: RPC must divide NR");
    end

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input int n);
        int s;
        s = n % W;
        if (s == 0) return v;
        return (v << s) | (v >> (W - s));
    endfunction

    // FIPS 202 rc(t): LFSR over x^8+x^6+x^5+x^4+1, seeded with R[0]=1
    function automatic logic rc_bit(input int t);
        logic [7:0] r;
        logic       fb;
        r = 8'h01;
        if ((t % 255) == 0) return 1'b1;
        for (int i = 1; i <= (t % 255); i++) begin
            fb   = r[7];
            r    = {r[6:0], 1'b0};
            r[0] = r[0] ^ fb;
            r[4] = r[4] ^ fb;
            r[5] = r[5] ^ fb;
            r[6] = r[6] ^ fb;
        end
        return r[0];
    endfunction

    function automatic logic [W-1:0] rc_lane(input int ir);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j <= L; j++) begin
            if (rc_bit(j + 7 * ir)) v = v | (W'(1) << ((1 << j) - 1));
        end
        return v;
    endfunction

    function automatic state_t round_f(input state_t a, input logic [W-1:0] rc);
        logic [W-1:0] c [5];
        logic [W-1:0] d [5];
        state_t       t;
        state_t       b;
        state_t       o;
        for (int x = 0; x < 5; x++) c[x] = a[x][0] ^ a[x][1] ^ a[x][2] ^ a[x][3] ^ a[x][4];
        for (int x = 0; x < 5; x++) d[x] = c[(x + 4) % 5] ^ rotl(c[(x + 1) % 5], 1);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                t[x][y] = rotl(a[x][y] ^ d[x], RHO[x][y]);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                b[y][(2 * x + 3 * y) % 5] = t[x][y];
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                o[x][y] = b[x][y] ^ (~b[(x + 1) % 5][y] & b[(x + 2) % 5][y]);
        o[0][0] = o[0][0] ^ rc;
        return o;
    endfunction

    // Round constants are fixed at elaboration; the table is padded to a power of two
    logic [W-1:0] rc_tab [2**IW];
    for (genvar i = 0; i < 2**IW; i++) begin : g_rc
        localparam logic [W-1:0] RC_I = (i < NRMAX) ? rc_lane(i) : '0;
        assign rc_tab[i] = RC_I;
    end

    fsm_e            state_q, state_d;
    state_t          a_q, a_d, a_run;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;

    always_comb begin
        a_run = a_q;
        for (int r = 0; r < RPC; r++) begin
            a_run = round_f(a_run, rc_tab[IW'(BASE + int'(cnt_q) + r)]);
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d = a_run;
                if (int'(cnt_q) + RPC == NR) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(RPC);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = done_q;
    assign bus.A_out = a_q;
endmodule

// File: tb/tb_keccak_p_core.sv
// Bench for keccak_p_core: three configurations checked against a
// lane-array Keccak-p reference model through an expected-result queue.
module tb_keccak_p_core;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keccak_p_core_if #(.W(64)) bus_a ();
    keccak_p_core_if #(.W(8))  bus_b ();
    keccak_p_core_if #(.W(64)) bus_c ();

    keccak_p_core #(.W(64), .NR(24), .RPC(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    keccak_p_core #(.W(8),  .NR(18), .RPC(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    keccak_p_core #(.W(64), .NR(24), .RPC(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    typedef logic [63:0] st_t [25];                 // lane (x,y) at index x+5*y
    typedef struct { int sel; st_t exp; int lat; } sb_t;
    typedef struct { int sel; int pat; bit has_const; logic [63:0] c00; logic [63:0] c10; } vec_t;

    sb_t sb_q [$];
    int  n_chk = 0;
    int  n_pass = 0;

    function automatic int cfg_w(input int sel);   return (sel == 1) ? 8 : 64; endfunction
    function automatic int cfg_nr(input int sel);  return (sel == 1) ? 18 : 24; endfunction
    function automatic int cfg_rpc(input int sel); return (sel == 0) ? 1 : ((sel == 1) ? 2 : 4); endfunction

    function automatic logic [63:0] lane_mask(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] mrot(input logic [63:0] v, input int n, input int w);
        logic [63:0] r;
        int          k;
        r = '0;
        k = n % w;
        for (int i = 0; i < w; i++) r[(i + k) % w] = v[i];
        return r;
    endfunction

    function automatic logic mrc(input int t);
        bit R [9];
        int m;
        m = t % 255;
        if (m == 0) return 1'b1;
        for (int i = 0; i < 9; i++) R[i] = (i == 0);
        for (int s = 0; s < m; s++) begin
            for (int i = 8; i > 0; i--) R[i] = R[i - 1];
            R[0] = 1'b0;
            R[0] ^= R[8]; R[4] ^= R[8]; R[5] ^= R[8]; R[6] ^= R[8];
        end
        return R[0];
    endfunction

    function automatic st_t model(input st_t a_in, input int w, input int nr);
        st_t         a;
        st_t         b;
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [63:0] mask;
        int          l, x, y, nx, base;
        l = 0;
        while ((1 << l) < w) l++;
        mask = lane_mask(w);
        for (int i = 0; i < 25; i++) a[i] = a_in[i] & mask;
        base = 12 + 2 * l - nr;
        for (int ir = base; ir < base + nr; ir++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i + 5] ^ a[i + 10] ^ a[i + 15] ^ a[i + 20];
            for (int i = 0; i < 5; i++) d[i] = c[(i + 4) % 5] ^ mrot(c[(i + 1) % 5], 1, w);
            for (int i = 0; i < 25; i++) a[i] = a[i] ^ d[i % 5];
            x = 1; y = 0;
            for (int t = 0; t < 24; t++) begin
                a[x + 5 * y] = mrot(a[x + 5 * y], (t + 1) * (t + 2) / 2, w);
                nx = y; y = (2 * x + 3 * y) % 5; x = nx;
            end
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    b[i + 5 * j] = a[(i + 3 * j) % 5 + 5 * i];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    a[i + 5 * j] = (b[i + 5 * j] ^ (~b[(i + 1) % 5 + 5 * j] & b[(i + 2) % 5 + 5 * j])) & mask;
            for (int j = 0; j <= l; j++)
                if (mrc(j + 7 * ir)) a[0] = a[0] ^ (64'd1 << ((1 << j) - 1));
        end
        return a;
    endfunction

    function automatic st_t mkpat(input int pat, input int w);
        st_t s;
        for (int i = 0; i < 25; i++) begin
            case (pat)
                0:       s[i] = '0;
                1:       s[i] = '1;
                2:       s[i] = mrot(64'h0123_4567_89AB_CDEF, 4 * i + 1, 64);
                default: s[i] = {$urandom, $urandom};
            endcase
            s[i] = s[i] & lane_mask(w);
        end
        return s;
    endfunction

    function automatic st_t get_out(input int sel);
        st_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                case (sel)
                    0:       s[x + 5 * y] = bus_a.A_out[x][y];
                    1:       s[x + 5 * y] = {56'd0, bus_b.A_out[x][y]};
                    default: s[x + 5 * y] = bus_c.A_out[x][y];
                endcase
        return s;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? bus_a.done : ((sel == 1) ? bus_b.done : bus_c.done);
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_a.busy : ((sel == 1) ? bus_b.busy : bus_c.busy);
    endfunction

    task automatic drive(input int sel, input logic go, input st_t s);
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                case (sel)
                    0:       bus_a.A_in[x][y] = s[x + 5 * y];
                    1:       bus_b.A_in[x][y] = s[x + 5 * y][7:0];
                    default: bus_c.A_in[x][y] = s[x + 5 * y];
                endcase
        case (sel)
            0:       bus_a.start = go;
            1:       bus_b.start = go;
            default: bus_c.start = go;
        endcase
    endtask

    task automatic chk(input bit ok, input string name, input string detail);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, detail);
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        chk(got == exp, name, $sformatf("got %0d, expected %0d", got, exp));
    endtask

    task automatic chk_st(input string name, input st_t got, input st_t exp);
        int bad;
        bad = -1;
        for (int i = 24; i >= 0; i--) if (got[i] !== exp[i]) bad = i;
        if (bad < 0) chk(1'b1, name, "");
        else chk(1'b0, name, $sformatf("lane x=%0d y=%0d got %h, expected %h",
                                        bad % 5, bad / 5, got[bad], exp[bad]));
    endtask

    // Called at a negedge; drives start immediately, returns at the negedge where done is seen.
    task automatic run(input int sel, input st_t s, input int poke1, input int poke2, output st_t got);
        sb_t item;
        int  e, busy_n, n;
        n = cfg_nr(sel) / cfg_rpc(sel);
        item.sel = sel;
        item.exp = model(s, cfg_w(sel), cfg_nr(sel));
        item.lat = n;
        sb_q.push_back(item);
        drive(sel, 1'b1, s);
        @(negedge clk);
        drive(sel, 1'b0, s);
        e = 0;
        busy_n = 0;
        while (!get_done(sel) && e < n + 8) begin
            if (get_busy(sel)) busy_n++;
            if (e == poke1 || e == poke2) drive(sel, 1'b1, mkpat(3, cfg_w(sel)));
            else drive(sel, 1'b0, s);
            @(negedge clk);
            e++;
        end
        drive(sel, 1'b0, s);
        got  = get_out(sel);
        item = sb_q.pop_front();
        if (!get_done(sel)) begin
            chk(1'b0, "done_timeout", $sformatf("dut %0d: no done within %0d cycles", sel, n + 8));
        end else begin
            chk_int($sformatf("latency_dut%0d", item.sel), e, item.lat);
            chk_int($sformatf("busy_cycles_dut%0d", item.sel), busy_n, item.lat);
            chk_st($sformatf("result_dut%0d", item.sel), got, item.exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [8];
        st_t  zero, got, s1, s2;
        int   e;

        zero = mkpat(0, 64);
        for (int sel = 0; sel < 3; sel++) drive(sel, 1'b0, zero);

        vt[0] = '{0, 0, 1'b1, 64'hF1258F7940E1DDE7, 64'h84D5CCF933C0478A};
        vt[1] = '{2, 0, 1'b1, 64'hF1258F7940E1DDE7, 64'h84D5CCF933C0478A};
        vt[2] = '{1, 0, 1'b0, 64'd0, 64'd0};
        vt[3] = '{0, 1, 1'b0, 64'd0, 64'd0};
        vt[4] = '{1, 1, 1'b0, 64'd0, 64'd0};
        vt[5] = '{2, 2, 1'b0, 64'd0, 64'd0};
        vt[6] = '{0, 2, 1'b0, 64'd0, 64'd0};
        vt[7] = '{1, 2, 1'b0, 64'd0, 64'd0};

        #1;
        for (int sel = 0; sel < 3; sel++) begin
            chk_int($sformatf("reset_busy_dut%0d", sel), int'(get_busy(sel)), 0);
            chk_int($sformatf("reset_done_dut%0d", sel), int'(get_done(sel)), 0);
            chk_st($sformatf("reset_state_dut%0d", sel), get_out(sel), zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run(vt[i].sel, mkpat(vt[i].pat, cfg_w(vt[i].sel)), -1, -1, got);
            if (vt[i].has_const) begin
                chk(got[0] === vt[i].c00, "known_lane00",
                    $sformatf("got %h, expected %h", got[0], vt[i].c00));
                chk(got[1] === vt[i].c10, "known_lane10",
                    $sformatf("got %h, expected %h", got[1], vt[i].c10));
            end
            @(negedge clk);
            chk_int("done_pulse_width", int'(get_done(vt[i].sel)), 0);
            repeat (2) @(negedge clk);
            chk_st("idle_stable", get_out(vt[i].sel), got);
        end

        for (int i = 0; i < 12; i++) begin
            run(i % 3, mkpat(3, cfg_w(i % 3)), -1, -1, got);
            @(negedge clk);
        end

        // starts while busy must be ignored
        run(0, mkpat(3, 64), 3, 10, got);
        @(negedge clk);
        run(1, mkpat(3, 8), 3, 6, got);
        @(negedge clk);

        // back-to-back: second start issued in the done cycle
        s1 = mkpat(3, 8);
        s2 = mkpat(3, 8);
        run(1, s1, -1, -1, got);
        run(1, s2, -1, -1, got);
        s1 = mkpat(3, 64);
        run(2, s1, -1, -1, got);
        run(2, mkpat(1, 64), -1, -1, got);
        @(negedge clk);

        // asynchronous reset between edges aborts the run
        drive(0, 1'b1, mkpat(3, 64));
        @(negedge clk);
        drive(0, 1'b0, zero);
        e = 0;
        while (e < 10) begin
            @(negedge clk);
            e++;
        end
        chk_int("busy_before_abort", int'(bus_a.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_int("abort_busy", int'(bus_a.busy), 0);
        chk_int("abort_done", int'(bus_a.done), 0);
        chk_st("abort_state", get_out(0), zero);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_int("after_abort_idle", int'(bus_a.busy), 0);
        run(0, zero, -1, -1, got);
        chk(got[0] === 64'hF1258F7940E1DDE7, "post_reset_lane00",
            $sformatf("got %h, expected %h", got[0], 64'hF1258F7940E1DDE7));
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
